// File: rtl/proc_pkg.sv
// Shared processor definitions: ISA opcodes, instruction field widths, sequencer state encoding.
// Used by the instruction sequencer, its PC unit, the instruction RAM and the control unit.
// Pure declarations; no logic, no timing.
package proc_pkg;

    localparam int OPCODE_W  = 6;
    localparam int OPERAND_W = 10;
    localparam int INSTR_W   = OPCODE_W + OPERAND_W;

    // ISA opcodes (6-bit)
    localparam logic [OPCODE_W-1:0] OP_CLAC   = 6'd2;
    localparam logic [OPCODE_W-1:0] OP_INAC   = 6'd7;
    localparam logic [OPCODE_W-1:0] OP_NOP    = 6'd46;
    localparam logic [OPCODE_W-1:0] OP_JUMPNZ = 6'd47;
    localparam logic [OPCODE_W-1:0] OP_JUMPZ  = 6'd52;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_EXEC  = 3'd4,
        ST_HALT  = 3'd5
    } seq_state_e;

    function automatic logic is_jump(input logic [OPCODE_W-1:0] op);
        return (op == OP_JUMPZ) || (op == OP_JUMPNZ);
    endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter: holds PC, clears, increments, loads jump targets and flags out-of-range addresses.
// Latency: PC updates on the clock edge after clr/inc/load; range flags are combinational from PC/target.
// Backpressure: none; the sequencer FSM decides when to step.
// Ports: clk/rst (sync active-high), clr_i/inc_i/load_i commands (clr > load > inc),
//        target_i jump target, pc_o current PC, inc_oob_o PC+1 >= PROG_LEN, target_oob_o target >= PROG_LEN.
module pc_unit
    import proc_pkg::*;
#(
    parameter int          PC_W     = 8,
    parameter int unsigned PROG_LEN = 166
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 inc_i,
    input  logic                 load_i,
    input  logic [OPERAND_W-1:0] target_i,
    output logic [PC_W-1:0]      pc_o,
    output logic                 inc_oob_o,
    output logic                 target_oob_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (clr_i) begin
            pc_d = '0;
        end else if (load_i) begin
            pc_d = target_i[PC_W-1:0];
        end else if (inc_i) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Compare at 32 bits so neither PC+1 nor the full 10-bit target can alias past PROG_LEN.
    assign inc_oob_o    = (32'(pc_q) + 32'd1) >= PROG_LEN;
    assign target_oob_o = 32'(target_i) >= PROG_LEN;
    assign pc_o         = pc_q;

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches words from instruction RAM, resolves jumps locally, issues the rest.
// Latency: FETCH->FETCH is 3 cycles for jumps, 4 cycles plus datapath wait for issued instructions.
// Backpressure: holds in EXEC until exec_done; start is ignored while busy.
// Ports: clk/rst (sync active-high), start pulse, instr_in RAM data, z_flag, exec_done;
//        instr_addr to RAM, ir_opcode/ir_operand/ir_valid to datapath, busy/halted/addr_err status.
module instr_sequencer
    import proc_pkg::*;
#(
    parameter int          PC_W     = 8,
    parameter int unsigned PROG_LEN = 166
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [INSTR_W-1:0]   instr_in,
    input  logic                 z_flag,
    input  logic                 exec_done,
    output logic [PC_W-1:0]      instr_addr,
    output logic [OPCODE_W-1:0]  ir_opcode,
    output logic [OPERAND_W-1:0] ir_operand,
    output logic                 ir_valid,
    output logic                 busy,
    output logic                 halted,
    output logic                 addr_err
);

    seq_state_e           state_q, state_d;
    logic [PC_W-1:0]      instr_addr_q;
    logic [OPCODE_W-1:0]  ir_opcode_q;
    logic [OPERAND_W-1:0] ir_operand_q;
    logic                 addr_err_q;

    logic            pc_clr, pc_inc, pc_load;
    logic            addr_ld, ir_ld, err_set, err_clr;
    logic            jump_taken;
    logic [PC_W-1:0] pc;
    logic            inc_oob, target_oob;

    pc_unit #(
        .PC_W     (PC_W),
        .PROG_LEN (PROG_LEN)
    ) u_pc (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (pc_clr),
        .inc_i        (pc_inc),
        .load_i       (pc_load),
        .target_i     (ir_operand_q),
        .pc_o         (pc),
        .inc_oob_o    (inc_oob),
        .target_oob_o (target_oob)
    );

    // z_flag only matters here, and this is only consulted in ISSUE.
    assign jump_taken = (ir_opcode_q == OP_JUMPZ) ? z_flag : ~z_flag;

    always_comb begin
        state_d  = state_q;
        pc_clr   = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        addr_ld  = 1'b0;
        ir_ld    = 1'b0;
        err_set  = 1'b0;
        err_clr  = 1'b0;
        ir_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_clr  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                addr_ld = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                ir_ld   = 1'b1;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (is_jump(ir_opcode_q)) begin
                    // Target range only matters when the branch is actually taken.
                    if (jump_taken) begin
                        if (target_oob) begin
                            err_set = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            pc_load = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end else if (inc_oob) begin
                        err_set = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_inc  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end else if (ir_opcode_q == OP_NOP) begin
                    state_d = ST_HALT;
                end else begin
                    ir_valid = 1'b1;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // exec_done seen during ISSUE never reaches here, so a same-cycle pulse is dropped.
                if (exec_done) begin
                    if (inc_oob) begin
                        err_set = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_inc  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                if (start) begin
                    pc_clr  = 1'b1;
                    err_clr = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            instr_addr_q <= '0;
            ir_opcode_q  <= '0;
            ir_operand_q <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (addr_ld) begin
                instr_addr_q <= pc;
            end
            if (ir_ld) begin
                ir_opcode_q  <= instr_in[INSTR_W-1:OPERAND_W];
                ir_operand_q <= instr_in[OPERAND_W-1:0];
            end
            if (err_clr) begin
                addr_err_q <= 1'b0;
            end else if (err_set) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    assign instr_addr = instr_addr_q;
    assign ir_opcode  = ir_opcode_q;
    assign ir_operand = ir_operand_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted     = (state_q == ST_HALT);
    assign addr_err   = addr_err_q;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter PC_W, default 8: program-counter width.
REQ-002 Parameter PROG_LEN, default 166: number of valid instruction words, addresses 0..PROG_LEN-1.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins execution from address 0 when the block is IDLE or HALT.
REQ-006 instr_in  input  16  instruction word from the instruction RAM; valid exactly one cycle after instr_addr is registered.
REQ-007 z_flag  input  1  datapath zero flag (AC == 0), sampled at jump decision.
REQ-008 exec_done  input  1  datapath completed the issued instruction.
REQ-009 instr_addr  output  PC_W  address driven to the instruction RAM.
REQ-010 ir_opcode  output  6  registered opcode, instr_in[15:10].
REQ-011 ir_operand  output  10  registered immediate/jump target, instr_in[9:0].
REQ-012 ir_valid  output  1  one-cycle pulse: ir_opcode/ir_operand are issued to the datapath.
REQ-013 busy  output  1  high in every state except IDLE and HALT.
REQ-014 halted  output  1  high in HALT.
REQ-015 addr_err  output  1  sticky: a jump target or sequential PC was >= PROG_LEN.

Function
REQ-016 States: IDLE, FETCH, WAIT, ISSUE, EXEC, HALT.
REQ-017 IDLE --start--> FETCH with PC=0; IDLE ignores exec_done and z_flag.
REQ-018 FETCH: instr_addr=PC registered; next state WAIT (one-cycle RAM latency).
REQ-019 WAIT: capture instr_in into ir_opcode/ir_operand; next ISSUE.
REQ-020 ISSUE: jump opcodes (JUMPZ=52, JUMPNZ=47) resolved here and never issued to the datapath; NOP=46 -> HALT, no ir_valid; all others -> ir_valid=1 for exactly this cycle, next EXEC.
REQ-021 JUMPZ: z_flag=1 -> PC=ir_operand[PC_W-1:0], else PC+1; JUMPNZ: z_flag=0 -> PC=ir_operand[PC_W-1:0], else PC+1; next FETCH.
REQ-022 Jump whose ir_operand >= PROG_LEN -> addr_err=1, HALT.
REQ-023 EXEC: wait for exec_done; on exec_done PC=PC+1, next FETCH; exec_done in the same cycle as ir_valid is ignored.
REQ-024 PC+1 == PROG_LEN -> addr_err=1, HALT (no wrap to 0).
REQ-025 FETCH-to-next-FETCH latency: 3 cycles for jumps, 4 cycles + datapath wait for single-cycle instructions.
REQ-026 HALT --start--> FETCH with PC=0, addr_err cleared; start in any busy state ignored.
REQ-027 z_flag sampled only in ISSUE of a jump; changes elsewhere have no effect.

Reset
REQ-028 rst=1 at any edge, including mid-EXEC: state=IDLE, PC=0, instr_addr=0, ir_opcode=0, ir_operand=0, ir_valid=0, busy=0, halted=0, addr_err=0.
REQ-029 rst has priority over start and exec_done in the same cycle.

Structure
REQ-030 Opcode constants (full ISA, 6-bit), state encoding, and instruction-field widths SHALL live in shared package proc_pkg, also used by the instruction RAM and control unit.
REQ-031 Sub-module pc_unit SHALL hold the PC register, increment, load, and range check; FSM stays in instr_sequencer.

Verification
REQ-032 rst, start; RAM[0..2]=CLAC,INAC,NOP; exec_done 1 cycle after each ir_valid -> ir_valid twice (opcodes 2, 7), instr_addr 0,1,2, halted=1, addr_err=0.
REQ-033 RAM[5]=JUMPZ 159, z_flag=1 -> no ir_valid for it, next instr_addr=159; repeat with z_flag=0 -> next instr_addr=6.
REQ-034 RAM[163]=JUMPNZ 63, z_flag=0 -> instr_addr=63; z_flag=1 -> instr_addr=164 then NOP -> halted.
REQ-035 exec_done delayed 10 cycles -> busy high, ir_valid single pulse, instr_addr unchanged until exec_done.
REQ-036 JUMPZ 200 with PROG_LEN=166, z_flag=1 -> addr_err=1, halted=1; start -> addr_err=0, instr_addr=0.
REQ-037 rst asserted in EXEC at PC=40 -> next cycle all outputs 0, state IDLE; start -> fetch from address 0.
